// File: rtl/autoref_issuer_pkg.sv
// rtl/autoref_issuer_pkg.sv - command codes, FSM states and default HBM2 refresh timings
package autoref_issuer_pkg;

    localparam logic [1:0] CMD_NOP  = 2'd0;
    localparam logic [1:0] CMD_PREA = 2'd1;
    localparam logic [1:0] CMD_REF  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_HOST,
        ST_PREA,
        ST_TRP,
        ST_REF,
        ST_TRFC
    } ref_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // U280 HBM2 fabric clock of roughly 300 MHz; timings rounded up to whole cycles.
    localparam int TCK_PS    = 3334;
    localparam int TRP_PS    = 12000;
    localparam int TRFC_PS   = 300000;
    localparam int DEF_T_RP  = ceil_div(TRP_PS, TCK_PS);
    localparam int DEF_T_RFC = ceil_div(TRFC_PS, TCK_PS);

endpackage

// File: rtl/autoref_issuer_ref_wait_timer.sv
// rtl/autoref_issuer_ref_wait_timer.sv - 8-bit loadable down-counter for tRP/tRFC waits
module ref_wait_timer (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    // Done on the last wait cycle, so a load of N gives exactly N cycles of waiting.
    assign done = (count == 8'd1);

endmodule

// File: rtl/autoref_issuer.sv
// rtl/autoref_issuer.sv - turns auto-refresh requests into PREA-all + REF on the HBM2 command port
module autoref_issuer
    import autoref_issuer_pkg::*;
#(
    parameter int T_RP     = DEF_T_RP,
    parameter int T_RFC    = DEF_T_RFC,
    parameter int MAX_PEND = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       autoref_req,
    output logic       autoref_ack,
    input  logic       exe_busy,
    output logic       ref_active,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_type,
    output logic [3:0] pend_cnt,
    output logic       ref_overflow
);

    localparam logic [3:0] PEND_LIMIT = 4'(MAX_PEND);

    ref_state_t state, state_nx;
    logic       accept;
    logic       ref_hs;
    logic       timer_load;
    logic [7:0] timer_val;
    logic       timer_done;
    logic       valid_nx;
    logic [1:0] type_nx;

    assign accept = autoref_req & ~autoref_ack;
    assign ref_hs = (state == ST_REF) & cmd_ready;

    // Ack and the pending count move together; simultaneous ack and REF cancel out.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            autoref_ack  <= 1'b0;
            pend_cnt     <= 4'd0;
            ref_overflow <= 1'b0;
        end else begin
            autoref_ack <= accept;
            if (accept && !ref_hs) begin
                if (pend_cnt == PEND_LIMIT) begin
                    ref_overflow <= 1'b1;
                end else begin
                    pend_cnt <= pend_cnt + 4'd1;
                end
            end else if (ref_hs && !accept) begin
                pend_cnt <= pend_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        timer_load = 1'b0;
        timer_val  = 8'(T_RP);
        case (state)
            ST_IDLE:      if (pend_cnt != 4'd0) state_nx = ST_WAIT_HOST;
            ST_WAIT_HOST: if (!exe_busy) state_nx = ST_PREA;
            ST_PREA: begin
                if (cmd_ready) begin
                    timer_load = 1'b1;
                    timer_val  = 8'(T_RP);
                    state_nx   = ST_TRP;
                end
            end
            ST_TRP:       if (timer_done) state_nx = ST_REF;
            ST_REF: begin
                if (cmd_ready) begin
                    timer_load = 1'b1;
                    timer_val  = 8'(T_RFC);
                    state_nx   = ST_TRFC;
                end
            end
            ST_TRFC: begin
                if (timer_done) state_nx = (pend_cnt != 4'd0) ? ST_PREA : ST_IDLE;
            end
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_nx = (state_nx == ST_PREA) || (state_nx == ST_REF);
        type_nx  = CMD_NOP;
        if (state_nx == ST_PREA) type_nx = CMD_PREA;
        if (state_nx == ST_REF)  type_nx = CMD_REF;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            cmd_valid  <= 1'b0;
            cmd_type   <= CMD_NOP;
            ref_active <= 1'b0;
        end else begin
            state      <= state_nx;
            cmd_valid  <= valid_nx;
            cmd_type   <= type_nx;
            ref_active <= (state_nx != ST_IDLE);
        end
    end

    ref_wait_timer u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

endmodule

// File: tb/tb_autoref_issuer.sv
// tb/tb_autoref_issuer.sv - self-checking bench for autoref_issuer with a timestamp-based model
module tb_autoref_issuer;

    localparam int T_RP     = 4;
    localparam int T_RFC    = 90;
    localparam int MAX_PEND = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       autoref_req = 1'b0;
    logic       autoref_ack;
    logic       exe_busy = 1'b0;
    logic       ref_active;
    logic       cmd_valid;
    logic       cmd_ready = 1'b1;
    logic [1:0] cmd_type;
    logic [3:0] pend_cnt;
    logic       ref_overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    bit started = 1'b0;

    // Model: expected outputs for the cycle after each posedge.
    int e_ack = 0, e_pend = 0, e_ovf = 0, e_cmd = 0, e_owned = 0;
    int ref_at = -1, free_at = -1;

    autoref_issuer #(.T_RP(T_RP), .T_RFC(T_RFC), .MAX_PEND(MAX_PEND)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .autoref_req  (autoref_req),
        .autoref_ack  (autoref_ack),
        .exe_busy     (exe_busy),
        .ref_active   (ref_active),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .pend_cnt     (pend_cnt),
        .ref_overflow (ref_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at rel cycle %0d: got %0d expected %0d", name, cyc - t0, act, exp);
        end
    endtask

    task automatic model_step();
        int  old_pend;
        bit  accept, ref_hs, prea_hs;
        if (!rstn) begin
            e_ack = 0; e_pend = 0; e_ovf = 0; e_cmd = 0; e_owned = 0;
            ref_at = -1; free_at = -1;
        end else begin
            accept   = autoref_req && (e_ack == 0);
            ref_hs   = (e_cmd == 2) && cmd_ready;
            prea_hs  = (e_cmd == 1) && cmd_ready;
            old_pend = e_pend;
            if (accept && !ref_hs) begin
                if (e_pend == MAX_PEND) e_ovf = 1;
                else e_pend = e_pend + 1;
            end else if (ref_hs && !accept) begin
                e_pend = e_pend - 1;
            end
            e_ack = accept ? 1 : 0;
            if (prea_hs) begin
                e_cmd = 0; ref_at = cyc + T_RP + 1;
            end else if (ref_hs) begin
                e_cmd = 0; free_at = cyc + T_RFC + 1;
            end else if (ref_at == cyc + 1) begin
                e_cmd = 2; ref_at = -1;
            end else if (free_at == cyc + 1) begin
                free_at = -1;
                if (old_pend != 0) e_cmd = 1;
                else e_owned = 0;
            end else if (e_owned == 0) begin
                if (old_pend != 0) e_owned = 1;
            end else if (e_cmd == 0 && ref_at < 0 && free_at < 0 && !exe_busy) begin
                e_cmd = 1;
            end
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        started = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("ack", int'(autoref_ack), e_ack);
            chk("cmd_valid", int'(cmd_valid), (e_cmd != 0) ? 1 : 0);
            chk("cmd_type", int'(cmd_type), e_cmd);
            chk("ref_active", int'(ref_active), e_owned);
            chk("pend_cnt", int'(pend_cnt), e_pend);
            chk("ref_overflow", int'(ref_overflow), e_ovf);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_rel(input int n);
        while (cyc - t0 < n) step();
    endtask

    task automatic do_reset();
        rstn = 1'b0; autoref_req = 1'b0; exe_busy = 1'b0; cmd_ready = 1'b1;
        repeat (3) step();
        rstn = 1'b1;
        t0 = cyc;
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_type", int'(cmd_type), 0);
        chk("rst_active", int'(ref_active), 0);
        chk("rst_pend", int'(pend_cnt), 0);
        chk("rst_ovf", int'(ref_overflow), 0);
        chk("rst_ack", int'(autoref_ack), 0);
    endtask

    task automatic do_req(input int at);
        goto_rel(at);
        autoref_req = 1'b1;
        goto_rel(at + 2);
        autoref_req = 1'b0;
    endtask

    initial begin
        int n_prea, falls, prev_act;

        // Single refresh, idle host
        do_reset();
        goto_rel(10); autoref_req = 1'b1;
        goto_rel(11); chk("t1_ack11", int'(autoref_ack), 1);
        goto_rel(12); autoref_req = 1'b0;
        chk("t1_active12", int'(ref_active), 1);
        goto_rel(13); chk("t1_prea13", int'(cmd_type), 1);
        chk("t1_valid13", int'(cmd_valid), 1);
        goto_rel(17); chk("t1_valid17", int'(cmd_valid), 0);
        goto_rel(18); chk("t1_ref18", int'(cmd_type), 2);
        goto_rel(108); chk("t1_active108", int'(ref_active), 1);
        goto_rel(109); chk("t1_active109", int'(ref_active), 0);
        chk("t1_pend109", int'(pend_cnt), 0);
        goto_rel(120);

        // Host busy holds off the PREA
        do_reset();
        exe_busy = 1'b1;
        do_req(10);
        chk("t2_active12", int'(ref_active), 1);
        goto_rel(199); chk("t2_valid199", int'(cmd_valid), 0);
        goto_rel(200); exe_busy = 1'b0;
        chk("t2_valid200", int'(cmd_valid), 0);
        goto_rel(201); chk("t2_prea201", int'(cmd_type), 1);
        goto_rel(310);

        // Backpressure on PREA
        do_reset();
        cmd_ready = 1'b0;
        do_req(10);
        for (int c = 13; c <= 17; c++) begin
            goto_rel(c);
            chk("t3_hold_valid", int'(cmd_valid), 1);
            chk("t3_hold_type", int'(cmd_type), 1);
        end
        goto_rel(18); cmd_ready = 1'b1;
        goto_rel(22); chk("t3_valid22", int'(cmd_valid), 0);
        goto_rel(23); chk("t3_ref23", int'(cmd_type), 2);
        goto_rel(130);

        // Postponement and saturation
        do_reset();
        exe_busy = 1'b1;
        for (int i = 0; i < 10; i++) do_req(10 + 3 * i);
        goto_rel(45);
        chk("t4_pend_sat", int'(pend_cnt), 8);
        chk("t4_ovf", int'(ref_overflow), 1);
        goto_rel(50); exe_busy = 1'b0;
        n_prea = 0; falls = 0; prev_act = int'(ref_active);
        while (cyc - t0 < 900) begin
            step();
            if (cmd_valid && cmd_ready && cmd_type == 2'd1) n_prea++;
            if (prev_act == 1 && !ref_active) falls++;
            prev_act = int'(ref_active);
        end
        chk("t4_prea_count", n_prea, 8);
        chk("t4_active_falls", falls, 1);
        chk("t4_pend_end", int'(pend_cnt), 0);
        chk("t4_ovf_sticky", int'(ref_overflow), 1);

        // Ack coinciding with REF handshake, then reset mid-TRFC
        do_reset();
        exe_busy = 1'b1;
        do_req(10); do_req(13); do_req(16);
        goto_rel(20); exe_busy = 1'b0;
        goto_rel(21); chk("t5_prea21", int'(cmd_type), 1);
        goto_rel(26); autoref_req = 1'b1;
        chk("t5_ref26", int'(cmd_type), 2);
        chk("t5_pend26", int'(pend_cnt), 3);
        goto_rel(27); chk("t5_pend27", int'(pend_cnt), 3);
        chk("t5_ack27", int'(autoref_ack), 1);
        goto_rel(28); autoref_req = 1'b0;
        goto_rel(60); rstn = 1'b0;
        goto_rel(61); rstn = 1'b1;
        chk("t6_active", int'(ref_active), 0);
        chk("t6_pend", int'(pend_cnt), 0);
        chk("t6_valid", int'(cmd_valid), 0);
        goto_rel(70); autoref_req = 1'b1;
        goto_rel(71); chk("t6_ack71", int'(autoref_ack), 1);
        goto_rel(72); autoref_req = 1'b0;
        goto_rel(73); chk("t6_prea73", int'(cmd_type), 1);
        goto_rel(78); chk("t6_ref78", int'(cmd_type), 2);
        goto_rel(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
